// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl -- pipeline hazard / stall controller for a 5-stage in-order core
//
// Purpose:
//   Generates the PC, IF/ID and ID/EX register enables and the IF/ID, ID/EX
//   and EX/MEM bubble-insert (flush) strobes. It handles three situations:
//     * load-use hazards     : one bubble via the LU_STALL state
//     * taken branches/jumps : squash the wrong-path fetch in IF/ID
//     * multi-cycle mult/div : freeze the front end until mdu_done, with a
//                              timeout that raises a sticky error flag
//   All control outputs are decoded combinationally from the current state
//   and the current inputs, so a hazard takes effect in the same cycle.
//
// Configuration macro:
//   PIPE_CTRL_STALL_CNT_EN - when defined, stall_cnt counts every cycle
//                            with pc_ena low (outside reset). When undefined,
//                            stall_cnt is tied to zero and no counter exists.
//
// Parameters:
//   REG_W   - register-index width
//   MDU_MAX - MDU wait-timeout limit in cycles (2..255)
//
// Ports:
//   clk           in   1      clock, rising edge
//   rst           in   1      asynchronous active-low reset
//   id_rs, id_rt  in   REG_W  source indices of the instruction in ID
//   id_use_rs/rt  in   1      ID instruction reads rs / rt
//   ex_is_load    in   1      EX holds a load
//   ex_rt         in   REG_W  load destination index
//   branch_taken  in   1      ID resolved a taken branch or jump
//   mdu_start     in   1      EX issues a multi-cycle mult/div
//   mdu_done      in   1      mult/div result valid
//   pc_ena        out  1      PC register enable
//   ifid_ena      out  1      IF/ID register enable
//   idex_ena      out  1      ID/EX register enable
//   ifid_flush    out  1      IF/ID bubble insert (overrides ifid_ena)
//   idex_flush    out  1      ID/EX bubble insert (overrides idex_ena)
//   exmem_flush   out  1      EX/MEM bubble insert
//   state         out  2      FSM state (0 RUN, 1 LU_STALL, 2 MDU_WAIT)
//   mdu_err       out  1      sticky MDU timeout flag, cleared only by reset
//   stall_cnt     out  32     stall-cycle counter
// ---------------------------------------------------------------------------
module pipe_ctrl #(
    parameter int REG_W   = 5,
    parameter int MDU_MAX = 40
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             ex_is_load,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             branch_taken,
    input  logic             mdu_start,
    input  logic             mdu_done,
    output logic             pc_ena,
    output logic             ifid_ena,
    output logic             idex_ena,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic [1:0]       state,
    output logic             mdu_err,
    output logic [31:0]      stall_cnt
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_MDU_WAIT = 2'd2,
        ST_ILLEGAL  = 2'd3
    } state_t;

    // Last wait-counter value before the timeout fires.
    localparam logic [7:0] MDU_LAST = 8'(MDU_MAX - 1);

    state_t     r_state;
    logic [7:0] r_wait_cnt;
    logic       r_mdu_err;

    state_t     w_nxt_state;
    logic [7:0] w_nxt_wait_cnt;
    logic       w_set_err;
    logic       w_lu_haz;
    logic       w_pc_ena;
    logic       w_ifid_ena;
    logic       w_idex_ena;
    logic       w_ifid_flush;
    logic       w_idex_flush;
    logic       w_exmem_flush;

    // Load-use hazard: the load in EX writes a register that ID reads.
    // Register 0 is hard-wired to zero, so it never creates a dependency.
    assign w_lu_haz = ex_is_load && (ex_rt != {REG_W{1'b0}}) &&
                      ((id_use_rs && (id_rs == ex_rt)) ||
                       (id_use_rt && (id_rt == ex_rt)));

    // Output decode and next-state logic.
    always_comb begin
        w_pc_ena       = 1'b1;
        w_ifid_ena     = 1'b1;
        w_idex_ena     = 1'b1;
        w_ifid_flush   = 1'b0;
        w_idex_flush   = 1'b0;
        w_exmem_flush  = 1'b0;
        w_nxt_state    = ST_RUN;
        w_nxt_wait_cnt = r_wait_cnt;
        w_set_err      = 1'b0;

        if (!rst) begin
            // Hold every stage and fill the pipe with bubbles while in reset.
            w_pc_ena      = 1'b0;
            w_ifid_ena    = 1'b0;
            w_idex_ena    = 1'b0;
            w_ifid_flush  = 1'b1;
            w_idex_flush  = 1'b1;
            w_exmem_flush = 1'b1;
            w_nxt_state   = ST_RUN;
        end else begin
            case (r_state)
                ST_RUN: begin
                    // A mult/div that completes in its issue cycle needs no
                    // stall, so it falls through to the lower priorities.
                    if (mdu_start && !mdu_done) begin
                        // Freeze the front end; a branch in ID is re-seen
                        // once the stall ends, so it is ignored here.
                        w_pc_ena       = 1'b0;
                        w_ifid_ena     = 1'b0;
                        w_idex_ena     = 1'b0;
                        w_exmem_flush  = 1'b1;
                        w_nxt_wait_cnt = 8'd0;
                        w_nxt_state    = ST_MDU_WAIT;
                    end else if (w_lu_haz) begin
                        w_pc_ena     = 1'b0;
                        w_ifid_ena   = 1'b0;
                        w_idex_flush = 1'b1;
                        w_nxt_state  = ST_LU_STALL;
                    end else if (branch_taken) begin
                        w_ifid_flush = 1'b1;
                        w_nxt_state  = ST_RUN;
                    end else begin
                        w_nxt_state = ST_RUN;
                    end
                end

                ST_LU_STALL: begin
                    // The bubble is already in ID/EX, so the hazard that is
                    // still visible this cycle is resolved by forwarding.
                    if (branch_taken) begin
                        w_ifid_flush = 1'b1;
                    end else begin
                        w_ifid_flush = 1'b0;
                    end
                    w_nxt_state = ST_RUN;
                end

                ST_MDU_WAIT: begin
                    if (mdu_done) begin
                        w_nxt_state = ST_RUN;
                    end else if (r_wait_cnt >= MDU_LAST) begin
                        // Give up on the unit and release the pipeline.
                        w_set_err   = 1'b1;
                        w_nxt_state = ST_RUN;
                    end else begin
                        w_pc_ena       = 1'b0;
                        w_ifid_ena     = 1'b0;
                        w_idex_ena     = 1'b0;
                        w_exmem_flush  = 1'b1;
                        w_nxt_wait_cnt = (r_wait_cnt == 8'hFF) ? r_wait_cnt
                                                               : r_wait_cnt + 8'd1;
                        w_nxt_state    = ST_MDU_WAIT;
                    end
                end

                default: begin
                    // Unused encoding: recover to RUN on the next edge.
                    w_nxt_state = ST_RUN;
                end
            endcase
        end
    end

    // FSM state, MDU wait counter and sticky timeout flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= 8'd0;
            r_mdu_err  <= 1'b0;
        end else begin
            r_state    <= w_nxt_state;
            r_wait_cnt <= w_nxt_wait_cnt;
            if (w_set_err) begin
                r_mdu_err <= 1'b1;
            end else begin
                r_mdu_err <= r_mdu_err;
            end
        end
    end

`ifdef PIPE_CTRL_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    // Stall-cycle counter; wraps naturally at 2^32.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= 32'd0;
        end else if (!w_pc_ena) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = 32'd0;
`endif

    assign pc_ena      = w_pc_ena;
    assign ifid_ena    = w_ifid_ena;
    assign idex_ena    = w_idex_ena;
    assign ifid_flush  = w_ifid_flush;
    assign idex_flush  = w_idex_flush;
    assign exmem_flush = w_exmem_flush;
    assign state       = r_state;
    assign mdu_err     = r_mdu_err;

endmodule
